// File: rtl/prefetch_pkg.sv
// Shared types and helpers for the instruction prefetch buffer.
package prefetch_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fsm_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } fifo_entry_t;

  function automatic logic [31:0] next_word(input logic [31:0] pc);
    return pc + 32'(WORD_BYTES);
  endfunction

  function automatic logic [31:0] align_word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// DEPTH-entry synchronous FIFO of {addr, data} words; clear beats push and pop.
module prefetch_fifo
  import prefetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  fifo_entry_t            push_entry_i,
  input  logic                   pop_i,
  output fifo_entry_t            head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  fifo_entry_t     r_mem [DEPTH];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_count;
  logic            w_push;
  logic            w_pop;

  assign full_o  = (r_count == Full);
  assign w_pop   = pop_i & (r_count != '0);
  assign w_push  = push_i & (~full_o | w_pop);
  assign count_o = r_count;
  assign head_o  = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
    end
  end

  // Storage is not reset; the head is only consumed while count is non-zero.
  always_ff @(posedge clk) begin
    if (w_push && !clear_i) r_mem[r_wr_ptr] <= push_entry_i;
  end

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Sequential instruction prefetcher with redirect flush and in-flight discard.
// Optional statistics counters enabled by defining PREFETCH_STATS_EN.
module instr_prefetch_buffer
  import prefetch_pkg::*;
#(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] BOOT_ADDR       = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_rdata_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_ready_i
`ifdef PREFETCH_STATS_EN
  ,
  output logic [15:0] stat_discard_o,
  output logic [15:0] stat_stall_o
`endif
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);

  fsm_state_e      r_state;
  fsm_state_e      w_state_nxt;
  logic [31:0]     r_fetch_pc;
  logic [31:0]     r_resp_pc;
  logic [OutW-1:0] r_outstanding;
  logic [OutW-1:0] w_outstanding_nxt;
  logic [OutW-1:0] r_discard;
  logic [OutW-1:0] w_discard_nxt;

  logic [CntW-1:0] w_count;
  logic            w_full;
  logic            w_valid;
  logic            w_credit_ok;
  logic            w_req;
  logic            w_gnt;
  logic            w_drop;
  logic            w_push;
  logic            w_pop;
  fifo_entry_t     w_head;
  fifo_entry_t     w_push_entry;
  logic            w_unused_addr_lsbs;

  assign w_unused_addr_lsbs = ^branch_addr_i[1:0];

  // Reserve FIFO space for every request still in flight so a push never overflows.
  assign w_credit_ok = ((32'(w_count) + 32'(r_outstanding)) < 32'(DEPTH)) &&
                       (32'(r_outstanding) < 32'(MAX_OUTSTANDING));
  assign w_req   = (r_state == FETCH) & fetch_en_i & ~branch_i & w_credit_ok;
  assign w_gnt   = w_req & mem_gnt_i;

  // A response landing in the redirect cycle is stale as well.
  assign w_drop  = mem_rvalid_i & (branch_i | (r_discard != '0));
  assign w_push  = mem_rvalid_i & ~w_drop;
  assign w_valid = (w_count != '0);
  assign w_pop   = w_valid & instr_ready_i & ~branch_i;

  assign w_push_entry.addr = r_resp_pc;
  assign w_push_entry.data = mem_rdata_i;

  prefetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (branch_i),
    .push_i       (w_push),
    .push_entry_i (w_push_entry),
    .pop_i        (w_pop),
    .head_o       (w_head),
    .count_o      (w_count),
    .full_o       (w_full)
  );

  always_comb begin
    w_outstanding_nxt = r_outstanding;
    if (w_gnt) w_outstanding_nxt = w_outstanding_nxt + OutW'(1);
    if (mem_rvalid_i && (w_outstanding_nxt != '0)) begin
      w_outstanding_nxt = w_outstanding_nxt - OutW'(1);
    end
  end

  always_comb begin
    w_discard_nxt = r_discard;
    if (branch_i) begin
      w_discard_nxt = w_outstanding_nxt;
    end else if (mem_rvalid_i && (r_discard != '0)) begin
      w_discard_nxt = r_discard - OutW'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (fetch_en_i) w_state_nxt = FETCH;
      FETCH:   if (!fetch_en_i && (r_outstanding == '0)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_fetch_pc    <= BOOT_ADDR;
      r_resp_pc     <= BOOT_ADDR;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_outstanding <= w_outstanding_nxt;
      r_discard     <= w_discard_nxt;
      if (branch_i) begin
        r_fetch_pc <= align_word(branch_addr_i);
        r_resp_pc  <= align_word(branch_addr_i);
      end else begin
        if (w_gnt)  r_fetch_pc <= next_word(r_fetch_pc);
        if (w_push) r_resp_pc  <= next_word(r_resp_pc);
      end
    end
  end

  assign mem_req_o     = w_req;
  assign mem_addr_o    = r_fetch_pc;
  assign instr_valid_o = w_valid;
  assign instr_rdata_o = w_valid ? w_head.data : '0;
  assign instr_addr_o  = w_valid ? w_head.addr : '0;

`ifdef PREFETCH_STATS_EN
  logic [15:0] r_stat_discard;
  logic [15:0] r_stat_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_discard <= '0;
      r_stat_stall   <= '0;
    end else begin
      if (w_drop && (r_stat_discard != 16'hFFFF)) r_stat_discard <= r_stat_discard + 16'd1;
      if ((r_state == FETCH) && instr_ready_i && !w_valid && (r_stat_stall != 16'hFFFF)) begin
        r_stat_stall <= r_stat_stall + 16'd1;
      end
    end
  end

  assign stat_discard_o = r_stat_discard;
  assign stat_stall_o   = r_stat_stall;
`endif

`ifndef SYNTHESIS
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && w_full && !w_pop));
`endif

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed bench for instr_prefetch_buffer: vector table plus redirect/stall sequences.
module tb_instr_prefetch_buffer;

  localparam logic [31:0] BOOT = 32'h0000_0000;

  typedef struct {
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_maddr;
    logic        exp_valid;
    logic [31:0] exp_iaddr;
    logic [31:0] exp_idata;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        fetch_en = 1'b0;
  logic        branch = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic [31:0] instr_rdata;
  logic [31:0] instr_addr;
  logic        instr_ready = 1'b0;

  // Memory model: latency 1 by default, 2 when lat2 is set (for in-flight discard).
  logic        lat2 = 1'b0;
  logic        v1, v2;
  logic [31:0] d1, d2;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_pc = '0;
  logic [31:0] req_log[$];
  vec_t        vecs[10];
  logic        found;

  always #5 clk = ~clk;

  instr_prefetch_buffer #(
    .DEPTH           (4),
    .MAX_OUTSTANDING (2),
    .BOOT_ADDR       (BOOT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_en_i    (fetch_en),
    .branch_i      (branch),
    .branch_addr_i (branch_addr),
    .mem_req_o     (mem_req),
    .mem_addr_o    (mem_addr),
    .mem_gnt_i     (mem_gnt),
    .mem_rvalid_i  (mem_rvalid),
    .mem_rdata_i   (mem_rdata),
    .instr_valid_o (instr_valid),
    .instr_rdata_o (instr_rdata),
    .instr_addr_o  (instr_addr),
    .instr_ready_i (instr_ready)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign mem_gnt = mem_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      d1 <= '0;
      d2 <= '0;
    end else begin
      v1 <= mem_req & mem_gnt;
      d1 <= mem_word(mem_addr);
      v2 <= v1;
      d2 <= d1;
    end
  end

  assign mem_rvalid = lat2 ? v2 : v1;
  assign mem_rdata  = lat2 ? d2 : d1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Observe one cycle (inputs already applied), then advance to just after the next edge.
  task automatic step();
    #1;
    if (instr_valid) check("head_data", instr_rdata, mem_word(instr_addr));
    if (instr_valid && instr_ready && !branch) begin
      check("pop_addr", instr_addr, exp_pc);
      exp_pc = exp_pc + 32'd4;
    end
    if (branch) exp_pc = {branch_addr[31:2], 2'b00};
    if (mem_req) req_log.push_back(mem_addr);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    fetch_en    = 1'b0;
    branch      = 1'b0;
    instr_ready = 1'b0;
    #1;
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_maddr", mem_addr, BOOT);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_rdata", instr_rdata, 32'd0);
    check("rst_iaddr", instr_addr, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    exp_pc = BOOT;
    req_log.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Startup with ready=1: req from cycle 1, first valid two cycles later.
    vecs[0] = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 32'h0000_0000};
    vecs[1] = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00, 32'h0000_0000};
    vecs[2] = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00, 32'h0000_0000};
    vecs[3] = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00, 32'h1000_0000};
    vecs[4] = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04, 32'h1000_0001};
    vecs[5] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08, 32'h1000_0002};
    vecs[6] = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h0C, 32'h1000_0003};
    vecs[7] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h10, 32'h1000_0004};
    vecs[8] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h14, 32'h1000_0005};
    vecs[9] = '{1'b1, 1'b1, 32'h20, 1'b1, 32'h18, 32'h1000_0006};

    #2;
    do_reset();

    for (int k = 0; k < 10; k++) begin
      fetch_en    = 1'b1;
      instr_ready = vecs[k].ready;
      #1;
      check($sformatf("v%0d_req", k), 32'(mem_req), 32'(vecs[k].exp_req));
      check($sformatf("v%0d_maddr", k), mem_addr, vecs[k].exp_maddr);
      check($sformatf("v%0d_valid", k), 32'(instr_valid), 32'(vecs[k].exp_valid));
      check($sformatf("v%0d_iaddr", k), instr_addr, vecs[k].exp_iaddr);
      check($sformatf("v%0d_idata", k), instr_rdata, vecs[k].exp_idata);
      step();
    end

    // Mid-stream reset with a non-empty FIFO.
    check("pre_reset_valid", 32'(instr_valid), 32'd1);
    do_reset();

    // Core stalled: exactly four words buffered, then requests stop.
    fetch_en    = 1'b1;
    instr_ready = 1'b0;
    repeat (20) step();
    check("stall_nreq", 32'(req_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < req_log.size(); i++) begin
      check($sformatf("stall_req%0d", i), req_log[i], 32'(i * 4));
    end
    check("stall_req_off", 32'(mem_req), 32'd0);
    check("stall_valid", 32'(instr_valid), 32'd1);
    check("stall_head", instr_addr, 32'h0);

    req_log.delete();
    instr_ready = 1'b1;
    repeat (8) step();
    check("drain_pc", exp_pc, 32'h20);
    check("resume_n", 32'(req_log.size() > 0), 32'd1);
    if (req_log.size() > 0) check("resume_addr", req_log[0], 32'h10);

    // Redirect in a cycle carrying both a response and a pop.
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (instr_valid && mem_rvalid) found = 1'b1;
      else step();
    end
    check("wait_rvalid_pop", 32'(found), 32'd1);
    branch      = 1'b1;
    branch_addr = 32'h200;
    #1;
    check("br_req_blocked", 32'(mem_req), 32'd0);
    step();
    branch = 1'b0;
    #1;
    check("br_flush", 32'(instr_valid), 32'd0);
    check("br_req", 32'(mem_req), 32'd1);
    check("br_maddr", mem_addr, 32'h200);
    repeat (6) step();
    check("br_pc", exp_pc, 32'h210);

    // Back-to-back redirects: only the second target survives.
    branch      = 1'b1;
    branch_addr = 32'h80;
    step();
    branch_addr = 32'h100;
    #1;
    check("b2b_flush", 32'(instr_valid), 32'd0);
    check("b2b_req", 32'(mem_req), 32'd0);
    step();
    branch = 1'b0;
    repeat (6) step();
    check("b2b_pc", exp_pc, 32'h110);

    // Fetch disable: in-flight data completes, then IDLE and a registered restart.
    fetch_en = 1'b0;
    #1;
    check("dis_req", 32'(mem_req), 32'd0);
    repeat (6) step();
    check("dis_pc", exp_pc, 32'h118);
    check("dis_empty", 32'(instr_valid), 32'd0);
    fetch_en = 1'b1;
    #1;
    check("idle_restart", 32'(mem_req), 32'd0);
    step();
    #1;
    check("restart_req", 32'(mem_req), 32'd1);
    check("restart_maddr", mem_addr, 32'h118);

    // Two-cycle memory: redirect with a response still in flight.
    lat2 = 1'b1;
    do_reset();
    fetch_en    = 1'b1;
    instr_ready = 1'b1;
    found       = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (i >= 6 && v1) found = 1'b1;
      else step();
    end
    check("wait_inflight", 32'(found), 32'd1);
    branch      = 1'b1;
    branch_addr = 32'h43;
    step();
    branch = 1'b0;
    #1;
    check("lat2_flush", 32'(instr_valid), 32'd0);
    check("lat2_maddr", mem_addr, 32'h40);
    repeat (12) step();
    check("lat2_progress", 32'(exp_pc > 32'h40), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_prefetch_buffer.md
Name: instr_prefetch_buffer

Overview:
- Fetch-side stage between the core's instruction interface and program_memory (req/addr/gnt/rvalid/rdata, 1-cycle read latency, gnt combinational from req).
- Issues sequential word fetches ahead of the core, buffers returned words with their addresses in a small FIFO, and serves them to the core via valid/ready.
- Handles branch redirects: flushes the FIFO, discards in-flight responses, restarts fetching at the target.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, >=2)
- MAX_OUTSTANDING, 2, max granted-but-unanswered memory requests
- BOOT_ADDR, 32'h0000_0000, first fetch address after reset

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- fetch_en_i  in  1  start fetching (sampled in IDLE)
- branch_i  in  1  redirect request, single-cycle pulse
- branch_addr_i  in  32  redirect target; bits [1:0] ignored
- mem_req_o  out  1  memory request
- mem_addr_o  out  32  word-aligned fetch address
- mem_gnt_i  in  1  request accepted this cycle
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  32  read data
- instr_valid_o  out  1  FIFO head valid
- instr_rdata_o  out  32  instruction word at head
- instr_addr_o  out  32  address of head word
- instr_ready_i  in  1  core accepts head

Behaviour:
- Reset values: mem_req_o=0, mem_addr_o=BOOT_ADDR, instr_valid_o=0, instr_rdata_o=0, instr_addr_o=0. Internal: fetch_pc=BOOT_ADDR, resp_pc=BOOT_ADDR, count=0, outstanding=0, discard=0, state=IDLE.
- FSM:
  - IDLE -> FETCH when fetch_en_i=1; the transition is registered.
  - FETCH -> IDLE when fetch_en_i=0 and outstanding=0. Buffered words are still served.
- mem_req_o is combinational: (state==FETCH) & fetch_en_i & !branch_i & (count+outstanding < DEPTH) & (outstanding < MAX_OUTSTANDING).
- mem_addr_o = fetch_pc.
- Request accepted (mem_req_o & mem_gnt_i): fetch_pc += 4 (32-bit wrap at 0xFFFF_FFFC -> 0), outstanding++.
- mem_rvalid_i: outstanding--.
  - If discard>0: discard--, data dropped.
  - Otherwise push {resp_pc, mem_rdata_i}, then resp_pc += 4.
- The credit rule guarantees a push never hits a full FIFO. An overflow attempt is a design error and is asserted in simulation.
- Core handshake:
  - Head is valid while count>0. Pop on instr_valid_o & instr_ready_i.
  - Push data becomes visible as head at the earliest the cycle after mem_rvalid_i (no bypass).
  - Latency: req at cycle N -> instr_valid_o at N+2.
- Simultaneous push and pop: count unchanged. Pop when empty: no effect.
- branch_i (priority over everything):
  - FIFO cleared (count=0, instr_valid_o=0 next cycle); any pop that cycle is void.
  - fetch_pc = resp_pc = {branch_addr_i[31:2],2'b00}. No request is issued that cycle.
  - discard = outstanding after the cycle's updates, i.e. a response arriving in the branch cycle is itself dropped, and all remaining in-flight responses are dropped.
  - Branch while discard>0: discard recomputed the same way (cumulative).
- fetch_en_i low in FETCH: no new requests; outstanding responses complete normally.
- Async reset mid-operation: all state to reset values immediately. Responses from pre-reset requests are not expected; the memory also resets.

Optional Feature:
- Macro: PREFETCH_STATS_EN.
- Defined:
  - Adds output stat_discard_o[15:0]: count of dropped responses, saturating at 16'hFFFF.
  - Adds output stat_stall_o[15:0]: cycles with instr_ready_i=1 & instr_valid_o=0 in FETCH, saturating.
  - Both reset to 0.
- Undefined: ports and counters absent; no other behaviour change.

Decomposition:
- Package prefetch_pkg: NOP_INSTR=32'h0000_0013, WORD_BYTES=4, fsm state typedef {IDLE, FETCH}, fifo entry struct {addr[31:0], data[31:0]}.
- One sub-module: prefetch_fifo. Synchronous DEPTH-entry FIFO with push, pop, clear, count, and head outputs; clear takes priority over push and pop.

Test Plan:
- Reset, fetch_en_i=1, memory preloaded mem[i]=32'h1000_0000+i, instr_ready_i=1 -> mem_addr_o 0,4,8,...; instr pairs (0,0x1000_0000),(4,0x1000_0001)... in order, first instr_valid_o 2 cycles after first mem_req_o.
- instr_ready_i=0 for 20 cycles -> exactly DEPTH=4 words buffered, mem_req_o=0 after; releasing ready drains addrs 0..0xC then fetching resumes at 0x10.
- branch_i with branch_addr_i=0x43 while one response in flight -> that response dropped, next instr_addr_o=0x40 with data mem[0x10], no stale word ever valid.
- branch_i in same cycle as mem_rvalid_i and a pop -> pop void, response dropped, FIFO empty next cycle, fetch restarts at target.
- Two back-to-back branches (0x80 then 0x100) -> only words from 0x100 onward reach the core.
- Assert rst_n low mid-stream with FIFO non-empty -> all outputs at reset values immediately; after release and fetch_en_i=1, fetch resumes at BOOT_ADDR.
